// File: rtl/mac_job_scheduler.sv
// mac_job_scheduler: round-robin arbiter that lends one shared MAC to requester streams, one dot-product job at a time
module mac_job_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int LEN_W = 8,
    parameter int CLR_CYC = 2,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   in_valid,
    output logic [NUM_REQ-1:0]   in_ready,
    input  logic [8*NUM_REQ-1:0] in_a,
    input  logic [8*NUM_REQ-1:0] in_b,
    input  logic [NUM_REQ-1:0]   in_last,
    output logic                 mac_clear,
    output logic                 mac_valid,
    output logic [7:0]           mac_a,
    output logic [7:0]           mac_b,
    input  logic                 mac_done,
    input  logic [31:0]          mac_y,
    input  logic                 mac_overflow,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_W-1:0]      res_id,
    output logic [31:0]          res_y,
    output logic [LEN_W-1:0]     res_count,
    output logic                 res_overflow,
    output logic                 busy
);
    localparam int CC_W = $clog2(CLR_CYC);
    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, FIRE, WAIT_DONE, SETTLE, RESULT} state_t;
    state_t state;
    logic [ID_W-1:0] rr_ptr, grant;
    logic [CC_W-1:0] clr_cnt;
    logic last, sel_valid, sel_last;
    logic [7:0] sel_a, sel_b;
    // grant the valid requester at the smallest distance above rr_ptr
    always_comb begin
        int best, d;
        best = NUM_REQ;
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i - int'(rr_ptr) + NUM_REQ) % NUM_REQ;
            if (in_valid[i] && d < best) begin
                best = d;
                grant = ID_W'(i);
            end
        end
    end
    // res_id doubles as the latched grant for the whole job
    always_comb begin
        sel_valid = 1'b0;
        sel_last = 1'b0;
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (res_id == ID_W'(i)) begin
                sel_valid = in_valid[i];
                sel_last = in_last[i];
                sel_a = in_a[8*i +: 8];
                sel_b = in_b[8*i +: 8];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            clr_cnt <= '0;
            last <= 1'b0;
            in_ready <= '0;
            mac_clear <= 1'b0;
            mac_valid <= 1'b0;
            mac_a <= '0;
            mac_b <= '0;
            res_valid <= 1'b0;
            res_id <= '0;
            res_y <= '0;
            res_count <= '0;
            res_overflow <= 1'b0;
            busy <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|in_valid) begin
                    res_id <= grant;
                    res_count <= '0;
                    res_overflow <= 1'b0;
                    clr_cnt <= '0;
                    mac_clear <= 1'b1;
                    busy <= 1'b1;
                    state <= CLEAR;
                end
                CLEAR: begin
                    mac_clear <= 1'b0;
                    clr_cnt <= clr_cnt + CC_W'(1);
                    if (clr_cnt == CC_W'(CLR_CYC - 1)) begin
                        in_ready <= NUM_REQ'(1) << res_id;
                        state <= ISSUE;
                    end
                end
                ISSUE: if (sel_valid) begin
                    in_ready <= '0;
                    mac_a <= sel_a;
                    mac_b <= sel_b;
                    last <= sel_last;
                    res_count <= (&res_count) ? res_count : res_count + LEN_W'(1);
                    mac_valid <= 1'b1;
                    state <= FIRE;
                end
                FIRE: begin
                    mac_valid <= 1'b0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: if (mac_done) begin
                    res_overflow <= res_overflow | mac_overflow;
                    state <= SETTLE;
                end
                SETTLE: begin
                    res_y <= mac_y;
                    if (last) begin
                        res_valid <= 1'b1;
                        state <= RESULT;
                    end else begin
                        in_ready <= NUM_REQ'(1) << res_id;
                        state <= ISSUE;
                    end
                end
                RESULT: if (res_ready) begin
                    res_valid <= 1'b0;
                    busy <= 1'b0;
                    rr_ptr <= (res_id == ID_W'(NUM_REQ - 1)) ? '0 : res_id + ID_W'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_job_scheduler.sv
// tb_mac_job_scheduler: directed and randomized jobs against a MAC stub and a job-level reference model
module tb_mac_job_scheduler;
    localparam int N = 2;
    localparam int LW = 8;
    localparam int CC = 2;
    localparam int IW = 1;
    typedef struct {logic [7:0] a; logic [7:0] b; logic last;} el_t;
    typedef struct {int id; logic [31:0] y; int cnt; logic ovf;} res_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] in_valid, in_ready, in_last;
    logic [8*N-1:0] in_a, in_b;
    logic mac_clear, mac_valid, mac_done, mac_overflow;
    logic [7:0] mac_a, mac_b;
    logic [31:0] mac_y;
    logic res_valid, res_overflow, busy;
    logic res_ready = 1'b1;
    logic [IW-1:0] res_id;
    logic [31:0] res_y;
    logic [LW-1:0] res_count;
    int checks = 0;
    int failures = 0;
    el_t q[N][$];
    int bub[N];
    logic [N-1:0] hs;
    res_t got[$];
    bit bp = 0;
    int ovf_elem = -1;
    logic [2:0] pipe = '0;
    logic signed [31:0] acc = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    mac_job_scheduler #(.NUM_REQ(N), .LEN_W(LW), .CLR_CYC(CC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mac_clear(mac_clear),
        .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b), .mac_done(mac_done),
        .mac_y(mac_y), .mac_overflow(mac_overflow), .res_valid(res_valid),
        .res_ready(res_ready), .res_id(res_id), .res_y(res_y), .res_count(res_count),
        .res_overflow(res_overflow), .busy(busy)
    );

    // MAC stub: done 3 cycles after valid, y one cycle after done, optional overflow on one element
    assign mac_done = pipe[2];
    assign mac_overflow = pipe[2] && (n_done == ovf_elem);
    assign mac_y = acc;
    always @(posedge clk) begin
        pipe <= {pipe[1:0], mac_valid};
        if (mac_clear) begin
            acc <= 0;
            n_done <= 0;
        end else if (pipe[2]) begin
            acc <= acc + $signed(mac_a) * $signed(mac_b);
            n_done <= n_done + 1;
        end
    end

    // requester streams: present queue heads, pop on accepted handshakes
    initial begin
        in_valid = '0;
        in_a = '0;
        in_b = '0;
        in_last = '0;
        forever begin
            @(negedge clk);
            hs = reset ? '0 : (in_valid & in_ready);
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && q[i].size() > 0) void'(q[i].pop_front());
                if (bub[i] > 0) begin
                    bub[i]--;
                    in_valid[i] = 1'b0;
                end else if (q[i].size() > 0) begin
                    in_valid[i] = 1'b1;
                    in_a[8*i +: 8] = q[i][0].a;
                    in_b[8*i +: 8] = q[i][0].b;
                    in_last[i] = q[i][0].last;
                end else begin
                    in_valid[i] = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (bp) res_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk)
        if (!reset && res_valid && res_ready)
            got.push_back('{int'(res_id), res_y, int'(res_count), res_overflow});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_el(input int r, input int a, input int b, input bit l);
        q[r].push_back('{8'(a), 8'(b), l});
    endtask

    task automatic add_job(input int r, input int n, output logic [31:0] y);
        int a, b;
        y = 0;
        for (int i = 0; i < n; i++) begin
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            y = y + 32'(a * b);
            add_el(r, a, b, i == n - 1);
        end
    endtask

    task automatic get_res(output res_t r);
        for (int k = 0; k < 4000 && got.size() == 0; k++) @(negedge clk);
        if (got.size() == 0) begin
            chk("result_timeout", got.size(), 1);
            r = '{-1, 32'd0, -1, 1'b0};
        end else begin
            r = got.pop_front();
        end
    endtask

    task automatic expect_res(input string tag, input int id, input logic [31:0] y, input int cnt, input bit ovf);
        res_t r;
        get_res(r);
        chk({tag, "_id"}, r.id, id);
        chk({tag, "_y"}, r.y, y);
        chk({tag, "_count"}, r.cnt, cnt);
        chk({tag, "_ovf"}, 32'(r.ovf), 32'(ovf));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            bub[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        got.delete();
    endtask

    initial begin
        logic [31:0] y, y0, y1;
        int rv, stalls, mv, rvc, rr, nj, g;
        int rdy[$];
        res_t pend[N][$];
        res_t e;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outs", 32'({in_ready, mac_clear, mac_valid, mac_a, mac_b, res_valid, res_id, res_overflow, busy}), 0);
        chk("reset_res_y", res_y, 0);
        chk("reset_count", 32'(res_count), 0);

        // single job timing
        @(posedge clk);
        #1;
        add_el(0, 3, 4, 0);
        add_el(0, -2, 5, 0);
        add_el(0, 7, -1, 1);
        for (int k = 0; k < 10 && !in_valid[0]; k++) @(negedge clk);
        rv = -1;
        for (int k = 0; k <= 22; k++) begin
            if (in_ready[0]) rdy.push_back(k);
            if (res_valid && rv < 0) rv = k;
            @(negedge clk);
        end
        chk("t1_nready", rdy.size(), 3);
        while (rdy.size() < 3) rdy.push_back(-1);
        for (int i = 0; i < 3; i++) chk("t1_ready_cycle", rdy[i], 3 + 6 * i);
        chk("t1_res_cycle", rv, 21);
        expect_res("t1", 0, -5, 3, 0);

        // contention after reset
        do_reset();
        add_el(0, 2, 3, 1);
        add_el(1, -4, 4, 1);
        expect_res("t2a", 0, 6, 1, 0);
        expect_res("t2b", 1, -16, 1, 0);
        add_el(0, 1, 1, 1);
        add_el(1, 1, 2, 1);
        expect_res("t2c", 0, 1, 1, 0);
        expect_res("t2d", 1, 2, 1, 0);

        // result backpressure
        res_ready = 1'b0;
        add_job(0, 2, y0);
        add_job(1, 3, y1);
        for (int k = 0; k < 200 && !res_valid; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", 32'(res_valid), 1);
            chk("t3_hold_y", res_y, y0);
            chk("t3_hold_count", 32'(res_count), 2);
            chk("t3_hold_id", 32'(res_id), 0);
            chk("t3_hold_ready", 32'(in_ready), 0);
            chk("t3_hold_macv", 32'(mac_valid), 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        expect_res("t3a", 0, y0, 2, 0);
        expect_res("t3b", 1, y1, 3, 0);

        // input bubble mid-job
        add_job(0, 3, y);
        for (int k = 0; k < 200 && !(in_valid[0] && in_ready[0]); k++) @(negedge clk);
        bub[0] = 9;
        stalls = 0;
        mv = 0;
        for (int k = 0; k < 200 && got.size() == 0; k++) begin
            @(negedge clk);
            if (in_ready[0] && !in_valid[0]) stalls++;
            if (mac_valid) mv++;
        end
        chk("t4_stalls", stalls, 4);
        chk("t4_mac_pulses", mv, 3);
        expect_res("t4", 0, y, 3, 0);

        // sticky overflow, then count saturation
        ovf_elem = 1;
        add_job(0, 4, y);
        expect_res("t5_ovf", 0, y, 4, 1);
        ovf_elem = -1;
        add_job(0, 257, y);
        expect_res("t5_sat", 0, y, 255, 0);

        // reset in WAIT_DONE
        add_job(0, 3, y);
        for (int k = 0; k < 200 && !mac_valid; k++) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < N; i++) q[i].delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_outs", 32'({in_ready, mac_clear, mac_valid, mac_a, mac_b, res_valid, res_id, res_overflow, busy}), 0);
        chk("t6_res_y", res_y, 0);
        rvc = 0;
        for (int k = 0; k < 20; k++) begin
            if (res_valid) rvc++;
            @(negedge clk);
        end
        chk("t6_no_result", rvc, 0);
        chk("t6_no_accept", got.size(), 0);
        add_el(0, 5, 5, 1);
        expect_res("t6b", 0, 25, 1, 0);

        // randomized rounds with random result backpressure
        do_reset();
        bp = 1;
        rr = 0;
        for (int round = 0; round < 4; round++) begin
            for (int r = 0; r < N; r++) begin
                nj = int'($urandom_range(1, 3));
                for (int j = 0; j < nj; j++) begin
                    e.cnt = int'($urandom_range(1, 6));
                    add_job(r, e.cnt, e.y);
                    e.id = r;
                    e.ovf = 1'b0;
                    pend[r].push_back(e);
                end
            end
            forever begin
                g = -1;
                for (int k = N - 1; k >= 0; k--)
                    if (pend[(rr + k) % N].size() > 0) g = (rr + k) % N;
                if (g < 0) break;
                e = pend[g].pop_front();
                expect_res("rand", e.id, e.y, e.cnt, e.ovf);
                rr = (g + 1) % N;
            end
        end
        bp = 0;
        res_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
